// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory byte loader.
package imem_loader_pkg;
    localparam int WORD_W          = 32;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_WORD  = 4;
    localparam int IMEM_DEPTH_LOG2 = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/imem_word_packer.sv
// Packs bytes MSB-first into 32-bit words; word_vld is combinational on the 4th byte.
// No internal storage beyond 3 bytes, so it never stalls the byte source.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [BYTE_W-1:0] byte_dat,
    output logic              word_vld,
    output logic [WORD_W-1:0] word_dat
);
    logic [1:0]               byte_cnt;
    logic [WORD_W-BYTE_W-1:0] shreg;

    assign word_vld = byte_vld && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    // Earlier bytes have been shifted toward the MSB, so the first byte lands in [31:24].
    assign word_dat = {shreg, byte_dat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (byte_vld) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {shreg[WORD_W-2*BYTE_W-1:0], byte_dat};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: one write 1 cycle after each 4th byte, 4 bytes per 5 cycles.
// in_ready drops in WRITE/DONE/IDLE; optional trailing XOR checksum byte under IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = IMEM_DEPTH_LOG2
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DEPTH_LOG2-1:0] word_count,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [BYTE_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [WORD_W-1:0]     wr_addr,
    output logic [WORD_W-1:0]     wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

    state_t                state, nxt;
    logic [DEPTH_LOG2-1:0] count_q;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [DEPTH_LOG2-1:0] idx_next;
    logic                  accept;
    logic                  byte_take;
    logic                  pack_clr;
    logic                  last_word;
    logic                  word_vld;
    logic [WORD_W-1:0]     word_dat;
    logic                  load_go;

    assign accept    = in_valid && in_ready;
    assign byte_take = accept && (state == S_RECV);
    assign load_go   = (state == S_IDLE) && start && !abort;
    assign pack_clr  = load_go || abort;
    assign idx_next  = word_idx + IDX_ONE;
    // A latched count of 0 means a full memory: idx wraps to 0 after the last word.
    assign last_word = (idx_next == count_q);

    imem_word_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pack_clr),
        .byte_vld (byte_take),
        .byte_dat (in_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = S_RECV;
            S_RECV:  if (word_vld) nxt = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_WRITE: nxt = last_word ? S_CHECK : S_RECV;
            S_CHECK: if (accept) nxt = S_DONE;
`else
            S_WRITE: nxt = last_word ? S_DONE : S_RECV;
`endif
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (abort) nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_addr  <= BASE_ADDR;
            wr_data  <= '0;
            count_q  <= '0;
            word_idx <= '0;
        end else begin
            state    <= nxt;
            in_ready <= (nxt == S_RECV) || (nxt == S_CHECK);
            wr_en    <= (nxt == S_WRITE);
            busy     <= (nxt != S_IDLE);
            done     <= (nxt == S_DONE);
            if (load_go) begin
                count_q  <= word_count;
                word_idx <= '0;
            end
            if ((state == S_RECV) && word_vld && !abort) begin
                wr_addr <= BASE_ADDR + {{(WORD_W-DEPTH_LOG2-2){1'b0}}, word_idx, 2'b00};
                wr_data <= word_dat;
            end
            if (state == S_WRITE) word_idx <= idx_next;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q <= '0;
            err   <= 1'b0;
        end else if (load_go) begin
            xor_q <= '0;
            err   <= 1'b0;
        end else begin
            if (byte_take) xor_q <= xor_q ^ in_data;
            // Err is sticky: only a fresh Start clears it, abort leaves it alone.
            if ((state == S_CHECK) && accept && !abort && (in_data != xor_q)) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule
